udp_video_rx_filter: RTL
========================

// Module: udp_video_rx_filter
// PURPOSE
//  Sits between the UDP stack's receive interface and the UDP-to-SDRAM pixel writer. Accepts only packets
//  for LOCAL_PORT. Validates an 8-byte video header and strips it; checks per-frame packet sequence.
//  Forwards only payload bytes of in-sequence packets as the byte stream (udp_data_valid/udp_data)
//  consumed downstream, so the writer never sees headers or partial frames.
// PARAMETERS
//  LOCAL_PORT   16'd8080  accepted UDP destination port
//  MAX_PAYLOAD  16'd1440  largest legal header payload length, bytes (multiple of 3)
// PORTS
//  clk              in   1   system clock (udp_clk domain); single clock
//  reset            in   1   synchronous, active-high reset
//  rx_valid         in   1   rx byte strobe from UDP stack
//  rx_data          in   8   rx payload byte
//  rx_last          in   1   with rx_valid: last byte of current UDP packet
//  rx_dst_port      in   16  destination port, stable for whole packet
//  udp_data_valid   out  1   forwarded payload byte strobe
//  udp_data         out  8   forwarded payload byte
//  frame_start      out  1   1-cycle pulse with first payload byte of packet seq 0
//  seq_err          out  1   1-cycle pulse on sequence mismatch
//  pkt_err          out  1   1-cycle pulse on bad magic/length/short packet
//  stat_pkt_ok      out  16  accepted-packet count (macro-dependent)
//  stat_pkt_drop    out  16  dropped-packet count (macro-dependent)
// BEHAVIOUR
//  Reset (sync, high): all outputs 0, state S_IDLE, expected seq 0, in_sync=0; reset mid-packet abandons it.
//  Header, big-endian: B0=8'h5A, B1=8'hA5, B2-3 frame_id, B4-5 pkt_seq, B6-7 payload_len.
//  States: S_IDLE -> S_HDR on any rx_valid (that byte is header byte 0); S_HDR -> S_PAYLOAD after byte 7 passes checks;
//   S_HDR/S_PAYLOAD -> S_DROP on error; every state -> S_IDLE on rx_valid&rx_last.
//  Port check at first byte: rx_dst_port!=LOCAL_PORT -> S_DROP, counted drop, no pkt_err.
//  Magic mismatch at B0/B1 -> pkt_err pulse, S_DROP.
//  payload_len==0, >MAX_PAYLOAD, or not multiple of 3 -> pkt_err, S_DROP.
//  rx_last inside header (packet <8 bytes) -> pkt_err, S_IDLE.
//  Sequence: pkt_seq==0 always resyncs (in_sync=1, frame_id latched, expected=1).
//   Else if !in_sync -> silently dropped.
//   Else if pkt_seq!=expected or frame_id!=latched -> seq_err, in_sync=0, dropped.
//   Else expected<=expected+1 (16-bit wrap allowed).
//  Payload: each accepted byte registered, 1-cycle latency rx->udp_data_valid; bytes beyond payload_len discarded.
//  rx_last before payload_len bytes (short) -> pkt_err, in_sync=0 (rest of frame dropped); bytes already sent stay sent.
//  frame_start asserted in same cycle as first forwarded byte of a seq-0 packet.
//  rx_valid gaps at any point are tolerated; no backpressure (downstream always accepts).
//  Packet counted ok when its final payload byte is forwarded, drop otherwise; single count per packet.
// CONFIGURATION
//  RX_STAT_CNT_EN defined: stat_pkt_ok/stat_pkt_drop count, saturate at 16'hFFFF, cleared by reset.
//  Not defined: both tied to 16'd0, no counter registers synthesized.
// STRUCTURE
//  Package udp_video_pkg: HDR_MAGIC0/1, HDR_LEN=8, state encoding localparams, header field offsets.
//  Sub-module udp_rx_stat_cnt: saturating 16-bit counter, instantiated twice under RX_STAT_CNT_EN.
//  Header byte counter 3-bit; payload counter 16-bit; seq/frame_id registers 16-bit.
// TESTING
//  1. Port 8080, hdr 5A A5 0001 0000 0006 + 6 bytes 01..06 -> frame_start with 01; six bytes out, 1-cycle lag; ok=1.
//  2. Same packet to port 9000 -> no udp_data_valid, no pkt_err; drop=1.
//  3. Seq 0,1,3 (frame 1) -> seq 0,1 forwarded; seq 3 gives seq_err; next seq 4 silently dropped.
//  4. payload_len=6 but rx_last after 4 payload bytes -> 4 bytes out, pkt_err; following seq 1 dropped.
//  5. B1=8'hA4 -> pkt_err, nothing forwarded. payload_len=1500 -> pkt_err.
//  6. Reset asserted mid-payload, then new seq-0 packet -> no stale bytes, clean frame_start; counters 0 after reset.

Source files
------------

// File: rtl/udp_video_pkg.sv
// ============================================================================
// Module  : udp_video_pkg
// Brief   : Shared constants, state encoding and header helpers for the
//           UDP video receive filter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package udp_video_pkg;

    localparam logic [7:0] HDR_MAGIC0 = 8'h5A;
    localparam logic [7:0] HDR_MAGIC1 = 8'hA5;
    localparam int         HDR_LEN    = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HDR     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_DROP    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_HDR     = ST_HDR,
        S_PAYLOAD = ST_PAYLOAD,
        S_DROP    = ST_DROP
    } rx_state_e;

    // Byte offsets inside the big-endian 8-byte video header
    localparam logic [2:0] OFS_MAGIC1   = 3'd1;
    localparam logic [2:0] OFS_FRAME_HI = 3'd2;
    localparam logic [2:0] OFS_FRAME_LO = 3'd3;
    localparam logic [2:0] OFS_SEQ_HI   = 3'd4;
    localparam logic [2:0] OFS_SEQ_LO   = 3'd5;
    localparam logic [2:0] OFS_LEN_HI   = 3'd6;
    localparam logic [2:0] OFS_LEN_LO   = 3'(HDR_LEN - 1);

    function automatic logic len_ok(input logic [15:0] len, input logic [15:0] max_len);
        return (len != 16'd0) && (len <= max_len) && ((len % 16'd3) == 16'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/udp_rx_stat_cnt.sv
// ============================================================================
// Module  : udp_rx_stat_cnt
// Brief   : 16-bit saturating event counter, synchronous active-high reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_rx_stat_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);

    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 16'd0;
        end else if (inc_i && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/udp_video_rx_filter.sv
// ============================================================================
// Module  : udp_video_rx_filter
// Brief   : Port filter, video header check/strip and per-frame sequence
//           check in front of the pixel writer. RX_STAT_CNT_EN enables the
//           packet statistics counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_video_rx_filter
    import udp_video_pkg::*;
#(
    parameter logic [15:0] LOCAL_PORT  = 16'd8080,
    parameter logic [15:0] MAX_PAYLOAD = 16'd1440
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_last,
    input  logic [15:0] rx_dst_port,
    output logic        udp_data_valid,
    output logic [7:0]  udp_data,
    output logic        frame_start,
    output logic        seq_err,
    output logic        pkt_err,
    output logic [15:0] stat_pkt_ok,
    output logic [15:0] stat_pkt_drop
);

    rx_state_e   state_q;
    logic [2:0]  hdr_cnt_q;
    logic [15:0] hdr_frame_q, hdr_seq_q, len_q, pay_cnt_q;
    logic [7:0]  len_hi_q;
    logic [15:0] frame_q, exp_seq_q;
    logic        in_sync_q, seq0_q;
    logic        valid_q, frame_start_q, seq_err_q, pkt_err_q;
    logic [7:0]  data_q;
    logic        ok_inc_q, drop_inc_q;

    logic [15:0] w_len;
    assign w_len = {len_hi_q, rx_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            hdr_cnt_q     <= 3'd0;
            hdr_frame_q   <= 16'd0;
            hdr_seq_q     <= 16'd0;
            len_hi_q      <= 8'd0;
            len_q         <= 16'd0;
            pay_cnt_q     <= 16'd0;
            frame_q       <= 16'd0;
            exp_seq_q     <= 16'd0;
            in_sync_q     <= 1'b0;
            seq0_q        <= 1'b0;
            valid_q       <= 1'b0;
            data_q        <= 8'd0;
            frame_start_q <= 1'b0;
            seq_err_q     <= 1'b0;
            pkt_err_q     <= 1'b0;
            ok_inc_q      <= 1'b0;
            drop_inc_q    <= 1'b0;
        end else begin
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
            seq_err_q     <= 1'b0;
            pkt_err_q     <= 1'b0;
            ok_inc_q      <= 1'b0;
            drop_inc_q    <= 1'b0;
            if (rx_valid) begin
                case (state_q)
                    S_IDLE: begin
                        hdr_cnt_q <= OFS_MAGIC1;
                        if (rx_dst_port != LOCAL_PORT) begin
                            drop_inc_q <= 1'b1;
                            state_q    <= rx_last ? S_IDLE : S_DROP;
                        end else if (rx_data != HDR_MAGIC0 || rx_last) begin
                            pkt_err_q  <= 1'b1;
                            drop_inc_q <= 1'b1;
                            state_q    <= rx_last ? S_IDLE : S_DROP;
                        end else begin
                            state_q <= S_HDR;
                        end
                    end
                    S_HDR: begin
                        hdr_cnt_q <= hdr_cnt_q + 3'd1;
                        case (hdr_cnt_q)
                            OFS_FRAME_HI: hdr_frame_q[15:8] <= rx_data;
                            OFS_FRAME_LO: hdr_frame_q[7:0]  <= rx_data;
                            OFS_SEQ_HI:   hdr_seq_q[15:8]   <= rx_data;
                            OFS_SEQ_LO:   hdr_seq_q[7:0]    <= rx_data;
                            OFS_LEN_HI:   len_hi_q          <= rx_data;
                            default: ;
                        endcase
                        if (hdr_cnt_q == OFS_MAGIC1 && rx_data != HDR_MAGIC1) begin
                            pkt_err_q  <= 1'b1;
                            drop_inc_q <= 1'b1;
                            state_q    <= rx_last ? S_IDLE : S_DROP;
                        end else if (hdr_cnt_q == OFS_LEN_LO) begin
                            state_q <= rx_last ? S_IDLE : S_DROP;
                            if (!len_ok(w_len, MAX_PAYLOAD)) begin
                                pkt_err_q  <= 1'b1;
                                drop_inc_q <= 1'b1;
                            end else if (hdr_seq_q != 16'd0 && !in_sync_q) begin
                                drop_inc_q <= 1'b1;
                            end else if (hdr_seq_q != 16'd0 &&
                                         (hdr_seq_q != exp_seq_q || hdr_frame_q != frame_q)) begin
                                seq_err_q  <= 1'b1;
                                in_sync_q  <= 1'b0;
                                drop_inc_q <= 1'b1;
                            end else begin
                                // Accepted header: seq 0 resyncs, otherwise advance
                                in_sync_q <= 1'b1;
                                seq0_q    <= (hdr_seq_q == 16'd0);
                                frame_q   <= hdr_frame_q;
                                exp_seq_q <= (hdr_seq_q == 16'd0) ? 16'd1 : exp_seq_q + 16'd1;
                                len_q     <= w_len;
                                pay_cnt_q <= 16'd0;
                                if (rx_last) begin
                                    pkt_err_q  <= 1'b1;
                                    in_sync_q  <= 1'b0;
                                    drop_inc_q <= 1'b1;
                                end else begin
                                    state_q <= S_PAYLOAD;
                                end
                            end
                        end else if (rx_last) begin
                            pkt_err_q  <= 1'b1;
                            drop_inc_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end
                    end
                    S_PAYLOAD: begin
                        valid_q       <= 1'b1;
                        data_q        <= rx_data;
                        frame_start_q <= seq0_q && (pay_cnt_q == 16'd0);
                        pay_cnt_q     <= pay_cnt_q + 16'd1;
                        if (pay_cnt_q + 16'd1 == len_q) begin
                            ok_inc_q <= 1'b1;
                            state_q  <= rx_last ? S_IDLE : S_DROP;
                        end else if (rx_last) begin
                            pkt_err_q  <= 1'b1;
                            in_sync_q  <= 1'b0;
                            drop_inc_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end
                    end
                    default: begin
                        if (rx_last) begin
                            state_q <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign udp_data_valid = valid_q;
    assign udp_data       = data_q;
    assign frame_start    = frame_start_q;
    assign seq_err        = seq_err_q;
    assign pkt_err        = pkt_err_q;

`ifdef RX_STAT_CNT_EN
    udp_rx_stat_cnt u_ok_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (ok_inc_q),
        .cnt_o (stat_pkt_ok)
    );

    udp_rx_stat_cnt u_drop_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (drop_inc_q),
        .cnt_o (stat_pkt_drop)
    );
`else
    logic w_unused_stat;
    assign w_unused_stat = ok_inc_q ^ drop_inc_q;
    assign stat_pkt_ok   = 16'd0;
    assign stat_pkt_drop = 16'd0;
`endif

endmodule

`default_nettype wire
